// File: rtl/alu_pkg.sv
// Shared ALU control codes and execution-unit state encoding.
package alu_pkg;

    localparam logic [2:0] ALUCONT_AND = 3'b000;
    localparam logic [2:0] ALUCONT_OR  = 3'b001;
    localparam logic [2:0] ALUCONT_ADD = 3'b010;
    localparam logic [2:0] ALUCONT_JR  = 3'b011;
    localparam logic [2:0] ALUCONT_MUL = 3'b100;
    localparam logic [2:0] ALUCONT_ILL = 3'b101;
    localparam logic [2:0] ALUCONT_SUB = 3'b110;
    localparam logic [2:0] ALUCONT_SLT = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles,
// low WIDTH bits of the product. done_o/product_o are combinational so the
// caller can register the final result on the same edge as the last iteration.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             busy;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;

    assign acc_nxt   = mplier[0] ? (acc + mcand) : acc;
    assign done_o    = busy && (count == LAST);
    assign product_o = acc_nxt;

    // Load operands on start, then one add/shift step per cycle until done.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy   <= 1'b0;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (start_i) begin
            busy   <= 1'b1;
            count  <= '0;
            mcand  <= a_i;
            mplier <= b_i;
            acc    <= '0;
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= done_o ? '0 : count + 1'b1;
            if (done_o)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle add/sub/and/or/slt/jr, iterative multiply
// with a valid/ready handshake that stalls the pipeline while mul runs.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       alucont_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             illegal_o
);
    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] diff;
    logic             slt_ovf;
    logic [WIDTH-1:0] sc_result;
    logic             sc_illegal;

    assign ready_o   = (state == IDLE);
    assign accept    = valid_i && ready_o;
    assign mul_start = accept && (alucont_i == ALUCONT_MUL);

    // Signed less-than from the subtractor: sign of a-b corrected by overflow.
    assign diff    = a_i - b_i;
    assign slt_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start),
        .a_i       (a_i),
        .b_i       (b_i),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // Single-cycle datapath; illegal code yields zero with the illegal flag.
    always_comb begin
        sc_result  = '0;
        sc_illegal = 1'b0;
        case (alucont_i)
            ALUCONT_AND: sc_result = a_i & b_i;
            ALUCONT_OR:  sc_result = a_i | b_i;
            ALUCONT_ADD: sc_result = a_i + b_i;
            ALUCONT_SUB: sc_result = diff;
            ALUCONT_SLT: sc_result = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ slt_ovf};
            ALUCONT_JR:  sc_result = a_i;
            ALUCONT_MUL: sc_result = '0;
            default:     sc_illegal = 1'b1;
        endcase
    end

    // Next-state: enter MUL on an accepted multiply, leave on its last step.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mul_start) state_nxt = MUL;
            MUL:     if (mul_done)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Output register: pulse valid_o with each new result, hold data otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o   <= 1'b0;
            result_o  <= '0;
            zero_o    <= 1'b0;
            illegal_o <= 1'b0;
        end else if (accept && !mul_start) begin
            valid_o   <= 1'b1;
            result_o  <= sc_result;
            zero_o    <= (sc_result == '0);
            illegal_o <= sc_illegal;
        end else if (state == MUL && mul_done) begin
            valid_o   <= 1'b1;
            result_o  <= mul_product;
            zero_o    <= (mul_product == '0);
            illegal_o <= 1'b0;
        end else begin
            valid_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: stimulus pushes expected responses
// (with the cycle they are due), a negedge monitor pops and compares.
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         valid_i;
    logic         ready_o;
    logic [2:0]   alucont_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         valid_o;
    logic [W-1:0] result_o;
    logic         zero_o;
    logic         illegal_o;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         ill;
        int           due;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .alucont_i (alucont_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .valid_o   (valid_o),
        .result_o  (result_o),
        .zero_o    (zero_o),
        .illegal_o (illegal_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid_o must match the oldest expectation, on its due cycle.
    always @(negedge clk) begin
        if (q.size() > 0 && cyc > q[0].due) begin
            checks++;
            errors++;
            $display("FAIL timeout: result due at cycle %0d never arrived (cycle %0d)", q[0].due, cyc);
            void'(q.pop_front());
        end
        if (valid_o) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: valid_o=1 with result 0x%08h, expected none (cycle %0d)", result_o, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", result_o, e.res);
                chk("zero", W'(zero_o), W'(e.z));
                chk("illegal", W'(illegal_o), W'(e.ill));
                chk("latency_cycle", W'(cyc), W'(e.due));
            end
        end
    end

    // Present one request in the current cycle; optionally queue its expected result.
    task automatic send(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit expect_res, input logic [W-1:0] r, input logic z,
                        input logic ill, input int lat);
        exp_t e;
        @(negedge clk);
        chk("ready_at_issue", W'(ready_o), W'(1));
        valid_i   = 1'b1;
        alucont_i = c;
        a_i       = a;
        b_i       = b;
        if (expect_res) begin
            e.res = r;
            e.z   = z;
            e.ill = ill;
            e.due = cyc + lat;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        valid_i = 1'b0;
        while (q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_i     = 1'b1;
        valid_i   = 1'b0;
        alucont_i = '0;
        a_i       = '0;
        b_i       = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", W'(valid_o), W'(0));
        chk("rst_result", result_o, 32'h0);
        chk("rst_zero", W'(zero_o), W'(0));
        chk("rst_illegal", W'(illegal_o), W'(0));
        chk("rst_ready", W'(ready_o), W'(1));
        rst_i = 1'b0;

        // Single-cycle ops
        send(ALUCONT_ADD, 32'h7FFFFFFF, 32'h00000001, 1, 32'h80000000, 0, 0, 1);
        send(ALUCONT_SUB, 32'd5, 32'd5, 1, 32'h0, 1, 0, 1);
        send(ALUCONT_SLT, 32'hFFFFFFFF, 32'h1, 1, 32'h1, 0, 0, 1);
        send(ALUCONT_SLT, 32'h1, 32'hFFFFFFFF, 1, 32'h0, 1, 0, 1);
        send(ALUCONT_SLT, 32'h80000000, 32'h7FFFFFFF, 1, 32'h1, 0, 0, 1);
        drain();

        // Back-to-back logical ops
        send(ALUCONT_AND, 32'h0000F0F0, 32'h0000FF00, 1, 32'h0000F000, 0, 0, 1);
        send(ALUCONT_OR,  32'h0000F0F0, 32'h0000FF00, 1, 32'h0000FFF0, 0, 0, 1);
        send(ALUCONT_JR,  32'h00400020, 32'h0000FF00, 1, 32'h00400020, 0, 0, 1);
        drain();

        // Multiply with an ignored request during the busy window; the next
        // request is issued in the same cycle valid_o pulses.
        send(ALUCONT_MUL, 32'h0000FFFF, 32'h00010001, 1, 32'hFFFFFFFF, 0, 0, W + 1);
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            chk("ready_low_in_mul", W'(ready_o), W'(0));
            valid_i   = 1'b1;
            alucont_i = ALUCONT_ADD;
            a_i       = 32'h11111111;
            b_i       = 32'h22222222;
        end
        send(ALUCONT_MUL, 32'hFFFFFFFD, 32'd7, 1, 32'hFFFFFFEB, 0, 0, W + 1);
        @(negedge clk);
        valid_i = 1'b0;
        a_i     = 32'hDEADBEEF;
        b_i     = 32'h00000003;
        drain();
        send(ALUCONT_MUL, 32'h12345678, 32'h0, 1, 32'h0, 1, 0, W + 1);
        drain();

        // Illegal code
        send(ALUCONT_ILL, 32'h12345678, 32'h9ABCDEF0, 1, 32'h0, 1, 1, 1);
        drain();

        // Reset in the middle of a multiply aborts it silently
        send(ALUCONT_MUL, 32'h00000003, 32'h00000005, 0, 32'h0, 0, 0, 0);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (9) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("abort_valid", W'(valid_o), W'(0));
        chk("abort_result", result_o, 32'h0);
        chk("abort_zero", W'(zero_o), W'(0));
        chk("abort_illegal", W'(illegal_o), W'(0));
        chk("abort_ready", W'(ready_o), W'(1));
        repeat (40) @(negedge clk);
        chk("abort_ready_later", W'(ready_o), W'(1));

        // Unit still works after the abort
        send(ALUCONT_ADD, 32'h00000010, 32'h00000020, 1, 32'h00000030, 0, 0, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
